seg7_card_rx: RTL
=================

Name: seg7_card_rx

Overview:
Receive-side counterpart of the card-to-7-segment encoder. It samples an active-low 7-segment pattern bus, waits until the pattern has been stable for a set number of cycles, and decodes it back to the 4-bit card code (A,2..10,J,Q,K). Each newly settled card is presented once over a valid/ready handshake. It is used for board-level loopback checking and for scoreboard capture of the displayed hand.

Parameters:
STABLE_CYCLES, 4, consecutive cycles the registered pattern must stay unchanged before decoding (legal range 1..15)

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  asynchronous, active-high reset
seg_in  input  7  active-low segment pattern, bit order {g,f,e,d,c,b,a}, same encoding as HEX0
card_code  output  4  decoded card: 1=A, 2..10, 11=J, 12=Q, 13=K; 0 when err
card_err  output  1  qualifies card_code; 1 = settled pattern is not a legal card glyph
card_valid  output  1  card_code/card_err valid
card_ready  input  1  consumer accepts on valid&&ready at rising clk
blank  output  1  1 while the last settled pattern is 7'b1111111

Behaviour:
- Reset (async assert, synchronous release): card_valid=0, card_code=0, card_err=0, blank=1, seg_q=7'b1111111, latched pattern=7'b1111111, cnt=0, state=S_HOLD.
- seg_in is registered once into seg_q every cycle.
- Stability counter cnt: if seg_q changes this cycle, cnt<=0; else cnt<=min(cnt+1, STABLE_CYCLES). Counter width is $clog2(STABLE_CYCLES+1).
- Decode (combinational on seg_q): the 13 legal glyphs map to codes 1..13. 7'b1111111 is blank. Any other pattern is illegal (code 0, err=1).
- FSM states:
  S_WAIT: the pattern has changed and has not yet settled. When seg_q is unchanged and cnt==STABLE_CYCLES-1:
    - if the pattern is blank: latch the pattern, blank<=1, go to S_HOLD, with no emission.
    - otherwise: latch the pattern, card_code, and card_err; blank<=0; card_valid<=1; go to S_EMIT.
    - If seg_q changes in S_WAIT, cnt restarts and the state stays S_WAIT.
  S_EMIT: card_valid=1. card_code and card_err are held constant regardless of seg_in. On valid&&ready: card_valid<=0.
    - If seg_q != latched pattern, go to S_WAIT, with cnt continuing from its current value.
    - Otherwise go to S_HOLD.
  S_HOLD: idle, card_valid=0. When seg_q != latched pattern, go to S_WAIT.
- Latency: with card_ready=1 and seg_in changed once and then held, card_valid rises at exactly rising edge STABLE_CYCLES+1 after seg_in first presents the new pattern. At most one card is held; there is no queue.
- Re-display: a pattern equal to the latched one (e.g. glitch X then back to same card) produces no new emission, provided it returns before settling. If it settles on X then returns, both X and the card are emitted.
- Blank→card→blank→same card emits the card twice.
- Backpressure: if the pattern changes and settles again while in S_EMIT, the newer card is emitted after the handshake plus settle.
  - Intermediate settled cards during the stall are lost; this is a defined behaviour.
- card_ready while card_valid=0 is ignored.
- Reset mid-handshake drops the pending card; no emission follows reset until a non-blank pattern settles.

Optional Feature:
SEG7_RX_DROP_ERR_EN
- Defined: illegal settled patterns are latched (blank<=0) but never emitted; the FSM goes directly to S_HOLD, and card_err is tied to 0.
- Undefined: illegal patterns are emitted with card_err=1 and card_code=0.

Decomposition:
- card_pkg holds:
  - HEX_* glyph constants (blank, A, 2..10, J, Q, K)
  - card_t enum (CARD_NONE=0, CARD_A=1 .. CARD_K=13)
  - rx_state_t enum {S_HOLD, S_WAIT, S_EMIT}
- The encoder and this block both import card_pkg so the glyph tables never diverge.
- One sub-module, seg7_glyph_decode: purely combinational, seg[6:0] -> {code[3:0], legal, is_blank}.
- seg7_card_rx contains the input register, counter, FSM, and output latch.

Test Plan:
1. Reset with seg_in=HEX_7 held and ready=1, STABLE_CYCLES=4 -> valid rises 5 edges after release, code=7, err=0, one pulse only.
2. All 13 glyphs applied in turn, each held 8 cycles, ready=1 -> codes 1..13 emitted in order; blank between them gives blank=1 and no emission.
3. seg_in=HEX_Q, then after 2 cycles HEX_K for 1 cycle, then HEX_Q held -> a single emission of code 12; no 13 is emitted.
4. ready=0: HEX_3 settles and valid=1 with code=3; change to HEX_9 (settled) then HEX_J (settled) while stalled; raise ready -> 3 accepted, then code=11 emitted 1 edge later; 9 is never seen.
5. seg_in=7'b1010101 held -> valid with err=1, code=0 (macro undefined); with SEG7_RX_DROP_ERR_EN, no valid ever occurs and blank=0.
6. Assert rst while valid=1 (code=5) -> valid=0 and blank=1 immediately (asynchronous); after release, with seg_in=HEX_5 still held, code 5 is re-emitted after STABLE_CYCLES+1 edges.

Source files
------------

// File: rtl/card_pkg.sv
// Shared card/glyph definitions for the card-to-7-segment encoder and receiver.
// Glyphs are active-low, bit order {g,f,e,d,c,b,a}, same as HEX0.
package card_pkg;

  localparam logic [6:0] HEX_BLANK = 7'b1111111;
  localparam logic [6:0] HEX_A     = 7'b0001000;
  localparam logic [6:0] HEX_2     = 7'b0100100;
  localparam logic [6:0] HEX_3     = 7'b0110000;
  localparam logic [6:0] HEX_4     = 7'b0011001;
  localparam logic [6:0] HEX_5     = 7'b0010010;
  localparam logic [6:0] HEX_6     = 7'b0000010;
  localparam logic [6:0] HEX_7     = 7'b1111000;
  localparam logic [6:0] HEX_8     = 7'b0000000;
  localparam logic [6:0] HEX_9     = 7'b0010000;
  localparam logic [6:0] HEX_10    = 7'b1000000;  // shown as "0"
  localparam logic [6:0] HEX_J     = 7'b1100001;
  localparam logic [6:0] HEX_Q     = 7'b0011000;  // shown as "q"
  localparam logic [6:0] HEX_K     = 7'b0001001;  // shown as "H"

  typedef enum logic [3:0] {
    CARD_NONE = 4'd0,
    CARD_A    = 4'd1,
    CARD_2    = 4'd2,
    CARD_3    = 4'd3,
    CARD_4    = 4'd4,
    CARD_5    = 4'd5,
    CARD_6    = 4'd6,
    CARD_7    = 4'd7,
    CARD_8    = 4'd8,
    CARD_9    = 4'd9,
    CARD_10   = 4'd10,
    CARD_J    = 4'd11,
    CARD_Q    = 4'd12,
    CARD_K    = 4'd13
  } card_t;

  typedef enum logic [1:0] {S_HOLD, S_WAIT, S_EMIT} rx_state_t;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational 7-segment glyph to card code decoder.
module seg7_glyph_decode
  import card_pkg::*;
(
  input  logic [6:0] seg_i,
  output card_t      code_o,
  output logic       legal_o,
  output logic       is_blank_o
);

  // Map each legal glyph to its card; blank and anything else are not cards.
  always_comb begin
    code_o     = CARD_NONE;
    legal_o    = 1'b1;
    is_blank_o = 1'b0;
    case (seg_i)
      HEX_A:     code_o = CARD_A;
      HEX_2:     code_o = CARD_2;
      HEX_3:     code_o = CARD_3;
      HEX_4:     code_o = CARD_4;
      HEX_5:     code_o = CARD_5;
      HEX_6:     code_o = CARD_6;
      HEX_7:     code_o = CARD_7;
      HEX_8:     code_o = CARD_8;
      HEX_9:     code_o = CARD_9;
      HEX_10:    code_o = CARD_10;
      HEX_J:     code_o = CARD_J;
      HEX_Q:     code_o = CARD_Q;
      HEX_K:     code_o = CARD_K;
      HEX_BLANK: begin
        legal_o    = 1'b0;
        is_blank_o = 1'b1;
      end
      default:   legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_card_rx.sv
// Receive side of the card 7-segment display: registers the segment bus, waits
// for the pattern to settle, decodes it and presents each new card once over
// valid/ready. Define SEG7_RX_DROP_ERR_EN to silently drop illegal patterns.
module seg7_card_rx
  import card_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  output logic [3:0] card_code,
  output logic       card_err,
  output logic       card_valid,
  input  logic       card_ready,
  output logic       blank
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax    = CntW'(STABLE_CYCLES);
  localparam logic [CntW-1:0] SettleCnt = CntW'(STABLE_CYCLES - 1);

`ifdef SEG7_RX_DROP_ERR_EN
  localparam bit DropErr = 1'b1;
`else
  localparam bit DropErr = 1'b0;
`endif

  logic [6:0]      seg_q, latch_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  rx_state_t       state_q;
  logic [3:0]      card_code_q;
  logic            card_err_q, card_valid_q, blank_q;

  card_t dec_code;
  logic  dec_legal, dec_blank;
  logic  seg_changed, settled, differs, pending;

  seg7_glyph_decode u_decode (
    .seg_i      (seg_q),
    .code_o     (dec_code),
    .legal_o    (dec_legal),
    .is_blank_o (dec_blank)
  );

  // Change detection, saturating stability count and settle qualification.
  always_comb begin
    seg_changed = (seg_in != seg_q);
    if (seg_changed)          cnt_d = '0;
    else if (cnt_q == CntMax) cnt_d = cnt_q;
    else                      cnt_d = cnt_q + 1'b1;
    // A saturated count also counts as settled so a pattern that settled
    // during a stall is taken straight after the handshake.
    settled = !seg_changed && (cnt_q >= SettleCnt);
    differs = (seg_q != latch_q);
    // HOLD with a new pattern behaves as WAIT so latency is the same from both.
    pending = (state_q == S_WAIT) || ((state_q == S_HOLD) && differs);
  end

  // Input register and stability counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q <= HEX_BLANK;
      cnt_q <= '0;
    end else begin
      seg_q <= seg_in;
      cnt_q <= cnt_d;
    end
  end

  // Settle/emit FSM with registered outputs and latched pattern.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_HOLD;
      latch_q      <= HEX_BLANK;
      card_code_q  <= '0;
      card_err_q   <= 1'b0;
      card_valid_q <= 1'b0;
      blank_q      <= 1'b1;
    end else begin
      case (state_q)
        S_HOLD, S_WAIT: begin
          if (pending) begin
            if (settled) begin
              latch_q <= seg_q;
              if (!differs) begin
                // Glitch returned to the displayed glyph: nothing new to report.
                state_q <= S_HOLD;
              end else if (dec_blank) begin
                blank_q <= 1'b1;
                state_q <= S_HOLD;
              end else if (!dec_legal && DropErr) begin
                blank_q <= 1'b0;
                state_q <= S_HOLD;
              end else begin
                card_code_q  <= dec_code;
                card_err_q   <= !dec_legal;
                blank_q      <= 1'b0;
                card_valid_q <= 1'b1;
                state_q      <= S_EMIT;
              end
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_EMIT: begin
          if (card_ready) begin
            card_valid_q <= 1'b0;
            state_q      <= differs ? S_WAIT : S_HOLD;
          end
        end
        default: state_q <= S_HOLD;
      endcase
    end
  end

  assign card_code  = card_code_q;
  assign card_err   = DropErr ? 1'b0 : card_err_q;
  assign card_valid = card_valid_q;
  assign blank      = blank_q;

endmodule
